// File: rtl/mjpg_slot_scheduler.sv
// MCU-row encode scheduler: round-robin fixed-length request slots per channel,
// per-channel encoded-MCU counters, and a 2-stage merger of header/encoder streams.
// state   | meaning
// ST_IDLE | waiting for start; slot counter, ereq and MCU counters held at 0
// ST_RUN  | slot counter cycles over PERIOD until the last channel reaches h_mcu
module mjpg_slot_scheduler #(
  parameter int NCH = 3,
  parameter logic [NCH*8-1:0] SLOT_LEN = {8'd6, 8'd6, 8'd28},
  parameter int GAP = 8,
  parameter int MCU_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MCU_W-1:0]     h_mcu,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overrun,
  output logic [NCH-1:0]       ereq,
  output logic [NCH*MCU_W-1:0] e_x_mcu,
  input  logic [5:0]           hdr_len,
  input  logic [31:0]          hdr_data,
  input  logic [NCH*6-1:0]     ce_len,
  input  logic [NCH*32-1:0]    ce_data,
  output logic [5:0]           out_len,
  output logic [31:0]          out_data,
  output logic                 err_collide
);

  function automatic int slot_len(input int k);
    return int'(SLOT_LEN[k*8 +: 8]);
  endfunction

  function automatic int slot_base(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += slot_len(i);
    return s;
  endfunction

  localparam int PERIOD = slot_base(NCH) + GAP;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
  localparam int NSRC = NCH + 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [NCH-1:0]     in_win;
  logic [NCH-1:0]     at_end;
  logic [MCU_W-1:0]   mcu_cnt [NCH];
  logic [MCU_W-1:0]   h_lat;
  logic               done_d;
  logic               last_hit;

  logic [5:0]         src_len  [NSRC];
  logic [31:0]        src_data [NSRC];

  assign src_len[0]  = hdr_len;
  assign src_data[0] = hdr_data;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int B = slot_base(g);
    localparam int L = slot_len(g);
    logic [CNT_W-1:0] off;

    // Offset wraps to a large value below the slot base, so one compare covers both bounds.
    assign off        = cnt - CNT_W'(B);
    assign in_win[g]  = off < CNT_W'(L);
    assign at_end[g]  = cnt == CNT_W'(B + L);
    assign e_x_mcu[g*MCU_W +: MCU_W] = mcu_cnt[g];

    assign src_len[g+1]  = ce_len[g*6 +: 6];
    assign src_data[g+1] = ce_data[g*32 +: 32];
  end

  assign last_hit = at_end[NCH-1] && ((mcu_cnt[NCH-1] + MCU_W'(1)) == h_lat);
  assign busy     = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (h_mcu != '0) state_d = ST_RUN;
          else             done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_hit) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done        <= 1'b0;
      err_overrun <= 1'b0;
      h_lat       <= '0;
      cnt         <= '0;
      ereq        <= '0;
      for (int k = 0; k < NCH; k++) mcu_cnt[k] <= '0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (start && state_q == ST_RUN)  err_overrun <= 1'b1;
      if (start && state_q == ST_IDLE) h_lat <= h_mcu;
      if (state_q == ST_RUN) begin
        cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        ereq <= in_win;
        for (int k = 0; k < NCH; k++) begin
          if (at_end[k]) mcu_cnt[k] <= mcu_cnt[k] + MCU_W'(1);
        end
      end else begin
        cnt  <= '0;
        ereq <= '0;
        for (int k = 0; k < NCH; k++) mcu_cnt[k] <= '0;
      end
    end
  end

  logic [5:0]  s1_len_d, s1_len;
  logic [31:0] s1_data_d [NSRC];
  logic [31:0] s1_data   [NSRC];
  logic        s1_coll_d, s1_coll;
  logic [3:0]  nz_cnt;
  logic [31:0] s2_data_d;

  always_comb begin
    s1_len_d = '0;
    nz_cnt   = '0;
    for (int i = 0; i < NSRC; i++) begin
      s1_len_d     = s1_len_d | src_len[i];
      s1_data_d[i] = (src_len[i] != '0) ? src_data[i] : '0;
      nz_cnt       = nz_cnt + 4'(src_len[i] != '0);
    end
    s1_coll_d = (nz_cnt >= 4'd2);
  end

  always_comb begin
    s2_data_d = '0;
    for (int i = 0; i < NSRC; i++) s2_data_d = s2_data_d | s1_data[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_len      <= '0;
      s1_coll     <= 1'b0;
      for (int i = 0; i < NSRC; i++) s1_data[i] <= '0;
      out_len     <= '0;
      out_data    <= '0;
      err_collide <= 1'b0;
    end else begin
      s1_len  <= s1_len_d;
      s1_coll <= s1_coll_d;
      for (int i = 0; i < NSRC; i++) s1_data[i] <= s1_data_d[i];
      out_len  <= s1_len;
      out_data <= s2_data_d;
      if (s1_coll) err_collide <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mjpg_slot_scheduler.sv
// Bench for mjpg_slot_scheduler: default 3-channel instance plus a 1-channel instance,
// compared each cycle against a closed-form schedule model and a 2-deep merge model.
module tb_mjpg_slot_scheduler;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance A (defaults)
  logic        rst_a, start_a, busy_a, done_a, ovr_a, coll_a;
  logic [7:0]  h_a;
  logic [2:0]  ereq_a;
  logic [23:0] exm_a;
  logic [5:0]  hdr_len, out_len;
  logic [31:0] hdr_data, out_data;
  logic [17:0] ce_len;
  logic [95:0] ce_data;

  // instance B (one channel, slot 4, gap 2)
  logic        rst_b, start_b, busy_b, done_b, ovr_b, coll_b;
  logic [7:0]  h_b;
  logic [0:0]  ereq_b;
  logic [7:0]  exm_b;
  logic [5:0]  hdr_len_b, ce_len_b, out_len_b;
  logic [31:0] hdr_data_b, ce_data_b, out_data_b;

  mjpg_slot_scheduler u_dut (
    .clk(clk), .rst(rst_a), .start(start_a), .h_mcu(h_a), .busy(busy_a), .done(done_a),
    .err_overrun(ovr_a), .ereq(ereq_a), .e_x_mcu(exm_a), .hdr_len(hdr_len), .hdr_data(hdr_data),
    .ce_len(ce_len), .ce_data(ce_data), .out_len(out_len), .out_data(out_data),
    .err_collide(coll_a)
  );

  mjpg_slot_scheduler #(.NCH(1), .SLOT_LEN(8'd4), .GAP(2), .MCU_W(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .h_mcu(h_b), .busy(busy_b), .done(done_b),
    .err_overrun(ovr_b), .ereq(ereq_b), .e_x_mcu(exm_b), .hdr_len(hdr_len_b),
    .hdr_data(hdr_data_b), .ce_len(ce_len_b), .ce_data(ce_data_b), .out_len(out_len_b),
    .out_data(out_data_b), .err_collide(coll_b)
  );

  int n_checks, n_pass, cyc;

  // schedule constants per instance
  int per_t [2];
  int nch_t [2];
  int base_t [2][3];
  int len_t  [2][3];

  // schedule model state
  bit act [2];
  int row_t [2];
  int row_h [2];
  int zdone [2];
  bit ovr_m [2];
  bit busy_m [2];

  // merge model: p1 = stage-1 content, p2 = what the outputs show this cycle
  logic [5:0]  p1_len, p2_len;
  logic [31:0] p1_data, p2_data;
  bit          p1_coll, coll_m;

  // stimulus for the next clock edge
  logic        nx_start_a, nx_rst_a, nx_start_b, nx_rst_b;
  logic [7:0]  nx_h_a, nx_h_b;
  logic [5:0]  nx_hdr_len;
  logic [31:0] nx_hdr_data;
  logic [17:0] nx_ce_len;
  logic [95:0] nx_ce_data;

  task automatic chk(input string tag, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act_v, exp_v, cyc);
  endtask

  // n = cycles since the cycle in which start was asserted
  function automatic bit exp_ereq(input int n, input int h, input int b, input int l, input int per);
    int ph;
    if (n < 2) return 1'b0;
    if ((n - 2) / per >= h) return 1'b0;
    ph = (n - 2) % per;
    return (ph >= b) && (ph < b + l);
  endfunction

  function automatic int exp_cnt(input int n, input int h, input int e, input int per);
    int c;
    c = 0;
    for (int p = 0; p < h; p++) if (p * per + e + 2 <= n) c++;
    return c;
  endfunction

  task automatic sched_check(input int i, input string nm, input logic b_v, input logic d_v,
                             input logic o_v, input logic [7:0] er_v, input logic [63:0] ex_v);
    int n, dn, last;
    logic [7:0]  er;
    logic [63:0] ex;
    bit bz, dz;
    er = '0; ex = '0; bz = 1'b0;
    dz = (zdone[i] == cyc);
    if (act[i]) begin
      last = nch_t[i] - 1;
      n  = cyc - row_t[i];
      dn = (row_h[i] - 1) * per_t[i] + base_t[i][last] + len_t[i][last] + 2;
      if (n > dn) act[i] = 1'b0;
      else begin
        bz = (n < dn);
        if (n == dn) dz = 1'b1;
        for (int k = 0; k < nch_t[i]; k++) begin
          er[k] = exp_ereq(n, row_h[i], base_t[i][k], len_t[i][k], per_t[i]);
          ex[k*8 +: 8] = 8'(exp_cnt(n, row_h[i], base_t[i][k] + len_t[i][k], per_t[i]));
        end
      end
    end
    busy_m[i] = bz;
    chk({nm, ".busy"}, 64'(b_v), 64'(bz));
    chk({nm, ".done"}, 64'(d_v), 64'(dz));
    chk({nm, ".err_overrun"}, 64'(o_v), 64'(ovr_m[i]));
    chk({nm, ".ereq"}, 64'(er_v), 64'(er));
    chk({nm, ".e_x_mcu"}, ex_v, ex);
  endtask

  task automatic sched_step(input int i, input logic st, input logic [7:0] h, input logic r);
    if (r) begin
      act[i] = 1'b0; zdone[i] = -1; ovr_m[i] = 1'b0;
    end else if (st) begin
      if (busy_m[i]) ovr_m[i] = 1'b1;
      else if (h != 8'd0) begin
        act[i] = 1'b1; row_t[i] = cyc; row_h[i] = int'(h);
      end else zdone[i] = cyc + 1;
    end
  endtask

  task automatic merge_step();
    logic [5:0]  l_arr [4];
    logic [31:0] d_arr [4];
    int nz;
    if (rst_a) begin
      p1_len = '0; p1_data = '0; p1_coll = 1'b0;
      p2_len = '0; p2_data = '0; coll_m = 1'b0;
    end else begin
      if (p1_coll) coll_m = 1'b1;
      p2_len = p1_len; p2_data = p1_data;
      l_arr[0] = hdr_len; d_arr[0] = hdr_data;
      for (int k = 0; k < 3; k++) begin
        l_arr[k+1] = ce_len[k*6 +: 6];
        d_arr[k+1] = ce_data[k*32 +: 32];
      end
      p1_len = '0; p1_data = '0; nz = 0;
      for (int s = 0; s < 4; s++) begin
        p1_len = p1_len | l_arr[s];
        if (l_arr[s] != 6'd0) begin
          p1_data = p1_data | d_arr[s];
          nz++;
        end
      end
      p1_coll = (nz >= 2);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sched_check(0, "A", busy_a, done_a, ovr_a, 8'(ereq_a), 64'(exm_a));
    sched_check(1, "B", busy_b, done_b, ovr_b, 8'(ereq_b), 64'(exm_b));
    chk("out_len", 64'(out_len), 64'(p2_len));
    chk("out_data", 64'(out_data), 64'(p2_data));
    chk("err_collide", 64'(coll_a), 64'(coll_m));
    start_a = nx_start_a; h_a = nx_h_a; rst_a = nx_rst_a;
    start_b = nx_start_b; h_b = nx_h_b; rst_b = nx_rst_b;
    hdr_len = nx_hdr_len; hdr_data = nx_hdr_data;
    ce_len = nx_ce_len; ce_data = nx_ce_data;
    sched_step(0, start_a, h_a, rst_a);
    sched_step(1, start_b, h_b, rst_b);
    merge_step();
    nx_start_a = 1'b0; nx_rst_a = 1'b0; nx_start_b = 1'b0; nx_rst_b = 1'b0;
    nx_hdr_len = '0; nx_ce_len = '0;
    cyc++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    per_t[0] = 48; nch_t[0] = 3;
    base_t[0][0] = 0;  len_t[0][0] = 28;
    base_t[0][1] = 28; len_t[0][1] = 6;
    base_t[0][2] = 34; len_t[0][2] = 6;
    per_t[1] = 6; nch_t[1] = 1;
    base_t[1][0] = 0; len_t[1][0] = 4;
    base_t[1][1] = 0; len_t[1][1] = 0;
    base_t[1][2] = 0; len_t[1][2] = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; row_t[i] = 0; row_h[i] = 0; zdone[i] = -1; ovr_m[i] = 1'b0; busy_m[i] = 1'b0;
    end
    p1_len = '0; p2_len = '0; p1_data = '0; p2_data = '0; p1_coll = 1'b0; coll_m = 1'b0;

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0; h_a = '0; h_b = '0;
    hdr_len = '0; hdr_data = '0; ce_len = '0; ce_data = '0;
    hdr_len_b = '0; hdr_data_b = '0; ce_len_b = '0; ce_data_b = '0;
    nx_start_a = 1'b0; nx_start_b = 1'b0; nx_h_a = '0; nx_h_b = '0;
    nx_hdr_len = '0; nx_hdr_data = '0; nx_ce_len = '0; nx_ce_data = '0;
    nx_rst_a = 1'b1; nx_rst_b = 1'b1;
    @(posedge clk);
    cycle();
    cycle();

    // 3-channel row of two MCUs; start asserted in cycle T
    nx_start_a = 1'b1; nx_h_a = 8'd2;
    cycle();
    for (int j = 1; j <= 92; j++) begin
      cycle();
      case (j)
        1:  chk("t1_busy_T+1", 64'(busy_a), 64'd1);
        2:  chk("t1_ereq_T+2", 64'(ereq_a), 64'h1);
        29: chk("t1_ereq_T+29", 64'(ereq_a), 64'h1);
        30: chk("t1_ereq_T+30", 64'(ereq_a), 64'h2);
        35: chk("t1_ereq_T+35", 64'(ereq_a), 64'h2);
        36: chk("t1_ereq_T+36", 64'(ereq_a), 64'h4);
        41: chk("t1_ereq_T+41", 64'(ereq_a), 64'h4);
        42: chk("t1_exm_T+42", 64'(exm_a), 64'h010101);
        89: chk("t1_busy_T+89", 64'(busy_a), 64'd1);
        90: begin
          chk("t1_done_T+90", 64'(done_a), 64'd1);
          chk("t1_busy_T+90", 64'(busy_a), 64'd0);
          chk("t1_exm_T+90", 64'(exm_a), 64'h020202);
        end
        91: chk("t1_exm_T+91", 64'(exm_a), 64'h0);
        default: ;
      endcase
    end

    // start while busy
    nx_start_a = 1'b1; nx_h_a = 8'd1;
    cycle();
    repeat (10) cycle();
    nx_start_a = 1'b1; nx_h_a = 8'd3;
    cycle();
    cycle();
    chk("t2_overrun_set", 64'(ovr_a), 64'd1);
    repeat (50) cycle();
    chk("t2_overrun_sticky", 64'(ovr_a), 64'd1);
    nx_rst_a = 1'b1;
    cycle();
    cycle();
    chk("t2_overrun_clr", 64'(ovr_a), 64'd0);

    // zero-length row
    nx_start_a = 1'b1; nx_h_a = 8'd0;
    cycle();
    cycle();
    chk("t3_done", 64'(done_a), 64'd1);
    chk("t3_busy", 64'(busy_a), 64'd0);
    cycle();
    chk("t3_done_low", 64'(done_a), 64'd0);
    chk("t3_ereq", 64'(ereq_a), 64'd0);

    // header alone
    nx_hdr_len = 6'd8; nx_hdr_data = 32'hFF;
    cycle();
    cycle();
    cycle();
    chk("t4_out_len", 64'(out_len), 64'd8);
    chk("t4_out_data", 64'(out_data), 64'hFF);
    chk("t4_no_collide", 64'(coll_a), 64'd0);

    // two encoders in the same cycle
    nx_ce_len = {6'd0, 6'd3, 6'd5};
    nx_ce_data = {32'h0, 32'h0000_0007, 32'h0000_0018};
    cycle();
    cycle();
    chk("t5_collide_early", 64'(coll_a), 64'd0);
    cycle();
    chk("t5_collide", 64'(coll_a), 64'd1);
    chk("t5_out_len", 64'(out_len), 64'd7);
    chk("t5_out_data", 64'(out_data), 64'h1F);
    repeat (5) cycle();
    chk("t5_collide_sticky", 64'(coll_a), 64'd1);

    // single-channel instance: three bursts of 4, period 6
    nx_start_b = 1'b1; nx_h_b = 8'd3;
    cycle();
    for (int j = 1; j <= 20; j++) begin
      cycle();
      case (j)
        2:  chk("t6_ereq_n2", 64'(ereq_b), 64'd1);
        5:  chk("t6_ereq_n5", 64'(ereq_b), 64'd1);
        6:  chk("t6_ereq_n6", 64'(ereq_b), 64'd0);
        8:  chk("t6_ereq_n8", 64'(ereq_b), 64'd1);
        18: begin
          chk("t6_done_n18", 64'(done_b), 64'd1);
          chk("t6_exm_n18", 64'(exm_b), 64'd3);
        end
        default: ;
      endcase
    end
    nx_start_b = 1'b1; nx_h_b = 8'd3;
    cycle();
    repeat (6) cycle();
    nx_rst_b = 1'b1;
    cycle();
    cycle();
    chk("t6_rst_busy", 64'(busy_b), 64'd0);
    chk("t6_rst_ereq", 64'(ereq_b), 64'd0);

    // randomized traffic on both instances
    nx_rst_a = 1'b1;
    cycle();
    for (int r = 0; r < 2500; r++) begin
      if ($urandom_range(0, 59) == 0) begin
        nx_start_a = 1'b1; nx_h_a = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 19) == 0) begin
        nx_start_b = 1'b1; nx_h_b = 8'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 299) == 0) nx_rst_a = 1'b1;
      if ($urandom_range(0, 199) == 0) nx_rst_b = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        nx_hdr_len = 6'($urandom_range(1, 40)); nx_hdr_data = $urandom;
      end
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          nx_ce_len[k*6 +: 6] = 6'($urandom_range(1, 40));
          nx_ce_data[k*32 +: 32] = $urandom;
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
